// File: rtl/pcie_tl_pkg.sv
// Shared definitions for the transaction-layer switch.
//   - tl_state_e : control FSM encoding (RESET/INIT/IDLE/ACTIVE/ERROR)
//   - ARB_*      : arbitration mode selectors
//   - clog2, vc_lsb, dest_lsb : elaboration-time helpers for field positions
package pcie_tl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } tl_state_e;

  localparam int ARB_STRICT = 0;  // lowest-index eligible VC wins
  localparam int ARB_RR     = 1;  // round-robin from the rotating pointer

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // VC field occupies the MSBs of a word.
  function automatic int vc_lsb(input int data_width, input int num_vc);
    return data_width - clog2(num_vc);
  endfunction

  // Destination field sits directly below the VC field.
  function automatic int dest_lsb(input int data_width, input int num_vc, input int num_dest);
    return data_width - clog2(num_vc) - clog2(num_dest);
  endfunction

endpackage

// File: rtl/pcie_tl_switch_n_fifo_fwft.sv
// First-word-fall-through FIFO used by every stage of the switch.
// The head word is combinationally visible on `head` whenever the FIFO is
// non-empty. A push while full is accepted only if a pop happens in the same
// cycle, so the occupancy never exceeds DEPTH.
// Ports:
//   clk, reset (async, active-low)
//   push/data_in  : write request and word
//   pop           : read request (ignored when empty)
//   head          : current head word
//   full/empty    : occupancy flags
//   count         : occupancy, 0..DEPTH
module fifo_fwft #(
  parameter int DATA_WIDTH    = 6,
  parameter int ADDRESS_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic [DATA_WIDTH-1:0]    head,
  output logic                     full,
  output logic                     empty,
  output logic [ADDRESS_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr_reg;
  logic [ADDRESS_WIDTH-1:0] rd_ptr_reg;
  logic [ADDRESS_WIDTH:0]   count_reg;
  logic                     do_push;
  logic                     do_pop;

  assign empty   = (count_reg == '0);
  // Occupancy tops out at exactly 2**ADDRESS_WIDTH, so the MSB alone means full.
  assign full    = count_reg[ADDRESS_WIDTH];
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: a flush just rewinds the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= data_in;
  end

endmodule

// File: rtl/pcie_tl_switch_n.sv
// Transaction-layer switch: main FIFO -> demux into NUM_VC VC FIFOs ->
// arbiter -> NUM_DEST destination FIFOs, sequenced by a control FSM.
// Ports:
//   clk, reset (async, active-low)
//   init                 : hold in INIT and latch the three thresholds
//   wr_enable, data_in   : push into main FIFO (IDLE/ACTIVE only)
//   umbral_MFs/VCs/Ds    : high watermarks for main / VC / dest FIFOs
//   D_pop                : per-destination pop request
//   data_out_D           : per-destination registered output word
//   empty_fifo_D         : per-destination empty flag
//   error_out            : sticky overflow flag
//   active_out, idle_out : registered FSM decodes
//   state_out            : present FSM state
module pcie_tl_switch_n
  import pcie_tl_pkg::*;
#(
  parameter int DATA_WIDTH    = 6,
  parameter int ADDRESS_WIDTH = 2,
  parameter int NUM_VC        = 2,
  parameter int NUM_DEST      = 2,
  parameter int ARB_MODE      = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           init,
  input  logic                           wr_enable,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic [ADDRESS_WIDTH:0]         umbral_MFs,
  input  logic [ADDRESS_WIDTH:0]         umbral_VCs,
  input  logic [ADDRESS_WIDTH:0]         umbral_Ds,
  input  logic [NUM_DEST-1:0]            D_pop,
  output logic [NUM_DEST*DATA_WIDTH-1:0] data_out_D,
  output logic [NUM_DEST-1:0]            empty_fifo_D,
  output logic                           error_out,
  output logic                           active_out,
  output logic                           idle_out,
  output logic [2:0]                     state_out
);

  localparam int DEPTH     = 1 << ADDRESS_WIDTH;
  localparam int VC_BITS   = clog2(NUM_VC);
  localparam int DEST_BITS = clog2(NUM_DEST);
  localparam int VC_LSB    = vc_lsb(DATA_WIDTH, NUM_VC);
  localparam int DEST_LSB  = dest_lsb(DATA_WIDTH, NUM_VC, NUM_DEST);
  localparam logic [ADDRESS_WIDTH:0] DEPTH_C = (ADDRESS_WIDTH+1)'(DEPTH);

  if (DATA_WIDTH < VC_BITS + DEST_BITS) begin : g_bad_fields
    $error("DATA_WIDTH too small for VC and destination fields");
  end

  // ---------------- control state ----------------
  tl_state_e              state_reg, state_next;
  logic                   active_reg, idle_reg, error_reg;
  logic [ADDRESS_WIDTH:0] mf_thr_reg, vc_thr_reg, d_thr_reg;
  logic [ADDRESS_WIDTH:0] vc_lim, d_lim;
  logic                   run;

  assign run    = (state_reg == ST_IDLE) || (state_reg == ST_ACTIVE);
  // A threshold above the physical depth behaves as the depth.
  assign vc_lim = (vc_thr_reg < DEPTH_C) ? vc_thr_reg : DEPTH_C;
  assign d_lim  = (d_thr_reg  < DEPTH_C) ? d_thr_reg  : DEPTH_C;

  // ---------------- main FIFO ----------------
  logic                   main_push, main_pop, main_full, main_empty;
  logic [DATA_WIDTH-1:0]  main_head;
  logic [ADDRESS_WIDTH:0] main_count;
  logic [VC_BITS-1:0]     main_vc;
  logic                   overflow;

  assign main_push = run && wr_enable;
  assign overflow  = main_push && main_full && !main_pop;
  assign main_vc   = main_head[VC_LSB +: VC_BITS];

  fifo_fwft #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH)) u_main_fifo (
    .clk(clk), .reset(reset), .push(main_push), .pop(main_pop), .data_in(data_in),
    .head(main_head), .full(main_full), .empty(main_empty), .count(main_count)
  );

  // ---------------- VC FIFOs ----------------
  logic [NUM_VC-1:0]      vc_push, vc_pop, vc_full, vc_empty, eligible;
  logic [DATA_WIDTH-1:0]  vc_head  [NUM_VC];
  logic [ADDRESS_WIDTH:0] vc_count [NUM_VC];
  logic [DEST_BITS-1:0]   vc_dest  [NUM_VC];

  // ---------------- destination FIFOs ----------------
  logic [NUM_DEST-1:0]    d_push, d_pop, d_full, d_empty;
  logic [DATA_WIDTH-1:0]  d_head   [NUM_DEST];
  logic [ADDRESS_WIDTH:0] d_count  [NUM_DEST];
  logic [DATA_WIDTH-1:0]  data_out_reg [NUM_DEST];
  logic [DATA_WIDTH-1:0]  win_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
      fifo_fwft #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH)) u_vc_fifo (
        .clk(clk), .reset(reset), .push(vc_push[gi]), .pop(vc_pop[gi]), .data_in(main_head),
        .head(vc_head[gi]), .full(vc_full[gi]), .empty(vc_empty[gi]), .count(vc_count[gi])
      );
      assign vc_dest[gi]  = vc_head[gi][DEST_LSB +: DEST_BITS];
      assign eligible[gi] = run && !vc_empty[gi] && !d_full[vc_dest[gi]]
                            && (d_count[vc_dest[gi]] < d_lim);
    end

    for (gi = 0; gi < NUM_DEST; gi++) begin : g_dest
      fifo_fwft #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH)) u_dest_fifo (
        .clk(clk), .reset(reset), .push(d_push[gi]), .pop(d_pop[gi]), .data_in(win_data),
        .head(d_head[gi]), .full(d_full[gi]), .empty(d_empty[gi]), .count(d_count[gi])
      );
      // Pops are honoured in every state except RESET, ERROR included.
      assign d_pop[gi] = D_pop[gi] && (state_reg != ST_RESET);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)                        data_out_reg[gi] <= '0;
        else if (d_pop[gi] && !d_empty[gi]) data_out_reg[gi] <= d_head[gi];
      end

      assign data_out_D[gi*DATA_WIDTH +: DATA_WIDTH] = data_out_reg[gi];
      assign empty_fifo_D[gi] = d_empty[gi];
    end
  endgenerate

  // Demux: a blocked head stalls the whole main FIFO (no bypass).
  always_comb begin
    main_pop = 1'b0;
    vc_push  = '0;
    if (run && !main_empty && !vc_full[main_vc] && (vc_count[main_vc] < vc_lim)) begin
      main_pop         = 1'b1;
      vc_push[main_vc] = 1'b1;
    end
  end

  // Arbiter: scan from base (0 in strict mode, rr_ptr in round-robin).
  logic [VC_BITS-1:0] rr_ptr_reg, base, idx, winner;
  logic               grant;

  always_comb begin
    base   = (ARB_MODE == ARB_RR) ? rr_ptr_reg : '0;
    idx    = '0;
    winner = '0;
    grant  = 1'b0;
    for (int i = 0; i < NUM_VC; i++) begin
      idx = base + VC_BITS'(i);
      if (!grant && eligible[idx]) begin
        grant  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    vc_pop   = '0;
    d_push   = '0;
    win_data = vc_head[winner];
    if (grant) begin
      vc_pop[winner]          = 1'b1;
      d_push[vc_dest[winner]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rr_ptr_reg <= '0;
    else if (grant) rr_ptr_reg <= winner + 1'b1;
  end

  // ---------------- FSM ----------------
  logic any_busy, mf_hold;

  assign any_busy = !main_empty || !(&vc_empty) || !(&d_empty);
  // Main occupancy at/above its watermark only keeps the switch ACTIVE.
  assign mf_hold  = !main_empty && (main_count >= mf_thr_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RESET: state_next = ST_INIT;
      ST_INIT:  state_next = init ? ST_INIT : ST_IDLE;
      ST_IDLE, ST_ACTIVE: begin
        if (overflow)                             state_next = ST_ERROR;
        else if (init)                            state_next = ST_INIT;
        else if (any_busy || wr_enable || mf_hold) state_next = ST_ACTIVE;
        else                                      state_next = ST_IDLE;
      end
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_RESET;
    endcase
  end

  // Decoded outputs are registered from the next state so they line up
  // with state_reg on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_RESET;
      active_reg <= 1'b0;
      idle_reg   <= 1'b0;
      error_reg  <= 1'b0;
      mf_thr_reg <= DEPTH_C;
      vc_thr_reg <= DEPTH_C;
      d_thr_reg  <= DEPTH_C;
    end else begin
      state_reg  <= state_next;
      active_reg <= (state_next == ST_ACTIVE);
      idle_reg   <= (state_next == ST_IDLE);
      error_reg  <= error_reg || (state_next == ST_ERROR);
      if (state_reg == ST_INIT) begin
        mf_thr_reg <= umbral_MFs;
        vc_thr_reg <= umbral_VCs;
        d_thr_reg  <= umbral_Ds;
      end
    end
  end

  assign state_out  = state_reg;
  assign active_out = active_reg;
  assign idle_out   = idle_reg;
  assign error_out  = error_reg;

endmodule

// File: tb/tb_pcie_tl_switch_n.sv
// Directed bench for pcie_tl_switch_n. Two instances share all inputs:
// dut0 uses strict priority, dut1 round-robin.
module tb_pcie_tl_switch_n;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init = 1'b0;
  logic        wr_enable = 1'b0;
  logic [5:0]  data_in = '0;
  logic [2:0]  umbral_MFs = 3'd4;
  logic [2:0]  umbral_VCs = 3'd4;
  logic [2:0]  umbral_Ds = 3'd4;
  logic [1:0]  D_pop = '0;

  logic [11:0] data_out_d0, data_out_d1;
  logic [1:0]  empty_d0, empty_d1;
  logic        error0, error1, active0, active1, idle0, idle1;
  logic [2:0]  state0, state1;

  int checks = 0;
  int failures = 0;

  pcie_tl_switch_n #(.ARB_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .init(init), .wr_enable(wr_enable), .data_in(data_in),
    .umbral_MFs(umbral_MFs), .umbral_VCs(umbral_VCs), .umbral_Ds(umbral_Ds), .D_pop(D_pop),
    .data_out_D(data_out_d0), .empty_fifo_D(empty_d0), .error_out(error0),
    .active_out(active0), .idle_out(idle0), .state_out(state0)
  );

  pcie_tl_switch_n #(.ARB_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .init(init), .wr_enable(wr_enable), .data_in(data_in),
    .umbral_MFs(umbral_MFs), .umbral_VCs(umbral_VCs), .umbral_Ds(umbral_Ds), .D_pop(D_pop),
    .data_out_D(data_out_d1), .empty_fifo_D(empty_d1), .error_out(error1),
    .active_out(active1), .idle_out(idle1), .state_out(state1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: value=%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_init(input logic [2:0] mf, input logic [2:0] vc, input logic [2:0] d);
    reset = 1'b0; init = 1'b0; wr_enable = 1'b0; data_in = '0; D_pop = '0;
    tick(); tick();
    reset = 1'b1; init = 1'b1;
    umbral_MFs = mf; umbral_VCs = vc; umbral_Ds = d;
    tick();          // RESET -> INIT
    tick();          // INIT, thresholds latched
    init = 1'b0;
    tick();          // -> IDLE
  endtask

  task automatic reinit(input logic [2:0] mf, input logic [2:0] vc, input logic [2:0] d);
    init = 1'b1;
    umbral_MFs = mf; umbral_VCs = vc; umbral_Ds = d;
    tick(); tick();
    init = 1'b0;
    tick();
  endtask

  task automatic write_word(input logic [5:0] w);
    wr_enable = 1'b1;
    data_in   = w;
    tick();
    wr_enable = 1'b0;
  endtask

  logic [5:0] exp_sp [4];
  logic [5:0] exp_rr [4];

  initial begin
    exp_sp = '{6'b000001, 6'b000010, 6'b100001, 6'b100010};
    exp_rr = '{6'b000001, 6'b100001, 6'b000010, 6'b100010};

    // ---- 1: reset values, bring-up, single-word latency ----
    #1 reset = 1'b0;
    #1;
    check("rst_state",  state0, 3'd0);
    check("rst_empty",  empty_d0, 2'b11);
    check("rst_error",  error0, 1'b0);
    check("rst_idle",   idle0, 1'b0);
    check("rst_active", active0, 1'b0);
    check("rst_dout",   data_out_d0, 12'h000);
    tick(); tick();
    reset = 1'b1; init = 1'b1;
    tick();
    check("init_state_a", state0, 3'd1);
    tick();
    check("init_state_b", state0, 3'd1);
    init = 1'b0;
    tick();
    check("idle_state", state0, 3'd2);
    check("idle_out",   idle0, 1'b1);
    write_word(6'b010011);                  // edge t
    check("active_out", active0, 1'b1);
    tick(); tick();                         // t+2
    check("lat_empty", empty_d0, 2'b01);
    D_pop = 2'b10;
    tick();                                 // t+3
    D_pop = 2'b00;
    check("lat_dout1", data_out_d0[11:6], 6'b010011);
    tick();
    check("back_idle", idle0, 1'b1);

    // ---- 2: strict priority vs round-robin into dest 0 ----
    reset_init(3'd4, 3'd4, 3'd0);           // dest threshold 0 parks words in VCs
    write_word(6'b000001);
    write_word(6'b100001);
    write_word(6'b000010);
    write_word(6'b100010);
    repeat (6) tick();
    check("arb_parked_empty", empty_d0, 2'b11);
    reinit(3'd4, 3'd4, 3'd4);
    repeat (6) tick();
    D_pop = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("sp_word%0d", i), data_out_d0[5:0], exp_sp[i]);
      check($sformatf("rr_word%0d", i), data_out_d1[5:0], exp_rr[i]);
    end
    D_pop = 2'b00;

    // ---- 3: dest watermark 2 blocks VC0, VC1 keeps flowing ----
    reset_init(3'd4, 3'd4, 3'd2);
    write_word(6'b000001);
    write_word(6'b000010);
    write_word(6'b000011);
    write_word(6'b010100);                  // VC0 -> dest1, stuck behind blocked head
    write_word(6'b110101);                  // VC1 -> dest1
    repeat (8) tick();
    check("wm_both_nonempty", empty_d0, 2'b00);
    D_pop = 2'b10;
    tick();
    D_pop = 2'b00;
    check("wm_vc1_flows", data_out_d0[11:6], 6'b110101);
    repeat (4) tick();
    check("wm_vc0_blocked", empty_d0, 2'b10);
    D_pop = 2'b01;
    tick();
    D_pop = 2'b00;
    check("wm_d0_first", data_out_d0[5:0], 6'b000001);
    repeat (4) tick();
    check("wm_unblocked", empty_d0, 2'b00);
    D_pop = 2'b10;
    tick();
    D_pop = 2'b00;
    check("wm_vc0_dest1", data_out_d0[11:6], 6'b010100);

    // ---- 4: overflow into ERROR, pops still served ----
    reset_init(3'd4, 3'd4, 3'd4);
    write_word(6'b011010);
    write_word(6'b011011);
    repeat (4) tick();
    reinit(3'd4, 3'd0, 3'd4);               // VC threshold 0 freezes the demux
    for (int i = 1; i <= 4; i++) write_word(6'(i));
    check("ovf_before", error0, 1'b0);
    write_word(6'b000101);
    check("ovf_error", error0, 1'b1);
    check("ovf_state", state0, 3'd4);
    check("ovf_active", active0, 1'b0);
    wr_enable = 1'b1; data_in = 6'b011111;
    tick(); tick();
    wr_enable = 1'b0;
    check("err_sticky_state", state0, 3'd4);
    check("err_no_new_words", empty_d0, 2'b01);
    D_pop = 2'b10;
    tick();
    check("err_drain_a", data_out_d0[11:6], 6'b011010);
    tick();
    D_pop = 2'b00;
    check("err_drain_b", data_out_d0[11:6], 6'b011011);
    check("err_drained", empty_d0, 2'b11);

    // ---- 5: push+pop on a full main FIFO ----
    reset_init(3'd4, 3'd4, 3'd4);
    for (int i = 1; i <= 12; i++) write_word(6'(i));
    repeat (8) tick();
    check("full_no_error", error0, 1'b0);
    D_pop = 2'b01;
    tick();                                 // P
    D_pop = 2'b00;
    check("full_first_out", data_out_d0[5:0], 6'd1);
    tick();                                 // P+1: arbiter refills dest 0
    wr_enable = 1'b1; data_in = 6'd13;
    tick();                                 // P+2: write with demux pop
    check("pushpop_error", error0, 1'b0);
    check("pushpop_state", state0, 3'd3);
    data_in = 6'd14;
    tick();                                 // P+3: main still holds 4
    wr_enable = 1'b0;
    check("still_full_error", error0, 1'b1);

    // ---- 6: reset mid-transfer ----
    reset_init(3'd4, 3'd4, 3'd4);
    write_word(6'b010111);
    tick(); tick();
    D_pop = 2'b10;
    tick();
    D_pop = 2'b00;
    check("mid_pre_dout", data_out_d0[11:6], 6'b010111);
    wr_enable = 1'b1; data_in = 6'b011001;
    tick();
    data_in = 6'b011010;
    tick();
    #2 reset = 1'b0;
    #1;
    check("mid_state",  state0, 3'd0);
    check("mid_empty",  empty_d0, 2'b11);
    check("mid_dout",   data_out_d0, 12'h000);
    check("mid_active", active0, 1'b0);
    check("mid_error",  error0, 1'b0);
    wr_enable = 1'b0;
    reset_init(3'd4, 3'd4, 3'd4);
    repeat (3) tick();
    check("rec_idle",  idle0, 1'b1);
    check("rec_empty", empty_d0, 2'b11);
    D_pop = 2'b11;
    tick();
    D_pop = 2'b00;
    check("rec_dout", data_out_d0, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcie_tl_switch_n.md
Name: pcie_tl_switch_n

Overview:
Parametrised transaction-layer switch: main input FIFO → demux into NUM_VC virtual-channel FIFOs → arbiter → NUM_DEST destination FIFOs, plus control FSM (RESET/INIT/IDLE/ACTIVE/ERROR).
Generalises the fixed 2-VC/2-dest, 6-bit datapath to any VC/dest count, width and depth.
Adds selectable strict-priority or round-robin arbitration, and per-stage watermark backpressure.

Parameters:
DATA_WIDTH, 6, word width; VC field = MSBs, dest field directly below.
ADDRESS_WIDTH, 2, FIFO depth = 2**ADDRESS_WIDTH (all FIFOs).
NUM_VC, 2, virtual channels (power of two, ≥2); VC_BITS = clog2(NUM_VC).
NUM_DEST, 2, destination FIFOs (power of two, ≥2); DEST_BITS = clog2(NUM_DEST).
ARB_MODE, 0, 0 = strict priority (lowest VC wins), 1 = round-robin.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
init  in  1  hold in INIT, latch thresholds.
wr_enable  in  1  push data_in into main FIFO.
data_in  in  DATA_WIDTH  input word.
umbral_MFs  in  ADDRESS_WIDTH+1  main FIFO high watermark.
umbral_VCs  in  ADDRESS_WIDTH+1  VC FIFO high watermark (all VCs).
umbral_Ds  in  ADDRESS_WIDTH+1  dest FIFO high watermark (all dests).
D_pop  in  NUM_DEST  per-dest pop request.
data_out_D  out  NUM_DEST*DATA_WIDTH  per-dest registered output word, dest k at [k*DATA_WIDTH +: DATA_WIDTH].
empty_fifo_D  out  NUM_DEST  per-dest empty flag.
error_out  out  1  sticky overflow error.
active_out  out  1  FSM in ACTIVE.
idle_out  out  1  FSM in IDLE.
state_out  out  3  present FSM state.

Behaviour:
- Reset (async, any time, incl. mid-transfer): all FIFOs flushed; data_out_D=0; empty_fifo_D all 1; error_out=0; active_out=0; idle_out=0; state=RESET; latched thresholds = DEPTH; RR pointer=0.
- FSM (3-bit: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4):
  - RESET → INIT on the first edge after reset deasserts.
  - INIT: latch all three umbrales every cycle; init=0 → IDLE.
  - IDLE: any FIFO non-empty or wr_enable → ACTIVE.
  - ACTIVE: all FIFOs empty and !wr_enable → IDLE.
  - init=1 in IDLE/ACTIVE → INIT.
  - Overflow in any state → ERROR, which exits only via reset.
- Outputs active_out, idle_out and state_out are registered from the FSM state.
- Writes: accepted only in IDLE/ACTIVE; ignored in RESET/INIT/ERROR.
- Overflow: wr_enable with main FIFO full and no same-cycle main pop drops the word and sets error_out.
  - Push+pop on a full FIFO in the same cycle is legal: no error, count unchanged.
- All FIFOs are first-word-fall-through (head combinationally visible).
- Demux: in IDLE/ACTIVE, pop main head and push to VC[head VC field] when main non-empty and that VC's count < min(umbral_VCs, DEPTH). One word per cycle; a blocked head stalls (no bypass).
- Arbiter: in IDLE/ACTIVE, each cycle select one VC.
  - Eligible VC: non-empty, and its head's dest FIFO count < min(umbral_Ds, DEPTH).
  - ARB_MODE=0: lowest-index eligible VC wins.
  - ARB_MODE=1: first eligible VC at or after the RR pointer; pointer advances to winner+1 mod NUM_VC on a grant only.
  - Winner is popped and pushed to its dest FIFO.
- umbral_MFs: main count ≥ umbral_MFs is used only to hold ACTIVE (no external flow control).
- Dest pop: D_pop[k] with dest k non-empty loads data_out_D[k] with head on that edge. Pop on empty is ignored (no error; data_out holds).
  - Pops are served in all states except RESET, including ERROR.
- ERROR: demux and arbiter frozen.
- Latency: word written at edge t → dest FIFO at edge t+2; empty_fifo_D deasserts after t+2; earliest data_out_D at edge t+3.
- Field indices: VC = data[DATA_WIDTH-1 -: VC_BITS]; dest = data[DATA_WIDTH-VC_BITS-1 -: DEST_BITS]. Elaboration error if DATA_WIDTH < VC_BITS+DEST_BITS.

Decomposition:
- Package pcie_tl_pkg: state encodings, clog2 helper, field-position functions, ARB_MODE constants.
- Sub-module fifo_fwft (DATA_WIDTH, ADDRESS_WIDTH): push/pop/full/empty/count, async active-low reset. Instantiated 1 + NUM_VC + NUM_DEST times via generate.
- Arbiter and FSM stay inline.

Test Plan:
- Reset, init=1 two cycles with umbrales 4/4/4, init=0 → state 0→1→2, idle_out=1; write 6'b010011 → after 3 edges, D_pop[1] gives data_out_D[1]=6'b010011.
- ARB_MODE=0: VC0 and VC1 both hold words for dest 0 → VC0 words emerge first; ARB_MODE=1 → emerge alternating VC0, VC1, VC0.
- umbral_Ds=2, never pop dest 0 → dest 0 count stays at 2; VC traffic to dest 1 keeps flowing.
- Freeze downstream, 5 writes with depth 4 → 5th raises error_out=1 and state_out=4; wr_enable ignored; D_pop drains stored words.
- Full main FIFO with simultaneous wr_enable and demux pop → no error, count stays 4.
- Assert reset mid-transfer → all outputs at reset values immediately; empty_fifo_D=all 1; no stale word after recovery.
